// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiplier datapath and its operand fetcher.
package mvm_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIM        = 8;

  // FIFO select value that addresses the B-vector FIFO; rows of A use 0..DIM-1.
  localparam int B_FIFO_SEL = DEF_DIM;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    UNPACK = 3'd3,
    DONE   = 3'd4
  } fetch_state_t;

endpackage : mvm_pkg

// File: rtl/avmm_data_fetcher_word_unpacker.sv
// Load/shift register that splits one memory word into bytes, MSB first.
// o_byte_out shows the top byte of i_word while loading, so the caller can
// register the first byte on the same edge the word is captured.
module word_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_load,
  input  logic [DIM*DATA_WIDTH-1:0]  i_word,
  input  logic                       i_shift,
  output logic [DATA_WIDTH-1:0]      o_byte_out,
  output logic                       o_last
);

  localparam int WORD_WIDTH = DIM * DATA_WIDTH;
  localparam int CNT_W      = $clog2(DIM + 1);

  logic [WORD_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_byte_idx;

  // Capture the word already advanced past byte 0, then shift one byte per request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg    <= '0;
      r_byte_idx <= '0;
    end else if (i_load) begin
      r_shreg    <= i_word << DATA_WIDTH;
      r_byte_idx <= '0;
    end else if (i_shift) begin
      r_shreg    <= r_shreg << DATA_WIDTH;
      r_byte_idx <= r_byte_idx + 1'b1;
    end
  end

  assign o_byte_out = i_load ? i_word[WORD_WIDTH-1 -: DATA_WIDTH]
                             : r_shreg[WORD_WIDTH-1 -: DATA_WIDTH];
  assign o_last     = (r_byte_idx == CNT_W'(DIM - 1));

endmodule : word_unpacker

// File: rtl/avmm_data_fetcher.sv
// Avalon-MM read master: fetches DIM rows of A plus one B word and streams
// them byte by byte into the multiplier operand FIFOs.
//
// state  | meaning
// IDLE   | waiting for start after reset
// REQ    | read asserted, waiting for the slave to accept
// WAIT   | one read outstanding, waiting for readdatavalid
// UNPACK | writing DIM bytes of the current word to the FIFOs
// DONE   | all DIM+1 words delivered; start restarts the fetch
import mvm_pkg::*;

module avmm_data_fetcher #(
  parameter int                   DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                   DIM        = DEF_DIM,
  parameter int                   ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int                   WORD_WIDTH = DIM * DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_read,
  input  logic                  i_waitrequest,
  input  logic [WORD_WIDTH-1:0] i_readdata,
  input  logic                  i_readdatavalid,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic [3:0]            o_fifo_sel,
  output logic                  o_fifo_wren,
  output logic                  o_fetch_done
);

  localparam int IDX_W = $clog2(DIM + 1);

  fetch_state_t          r_state;
  logic [IDX_W-1:0]      r_word_idx;
  logic                  r_read;
  logic [ADDR_WIDTH-1:0] r_address;
  logic                  r_fifo_wren;
  logic [DATA_WIDTH-1:0] r_fifo_data;
  logic [3:0]            r_fifo_sel;
  logic                  r_fetch_done;
  logic                  r_busy;

  logic                  w_load;
  logic                  w_shift;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_byte;

  assign w_load  = (r_state == WAIT) && i_readdatavalid;
  assign w_shift = (r_state == UNPACK) && !w_last;

  word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM        (DIM)
  ) u_unpacker (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_word     (i_readdata),
    .i_shift    (w_shift),
    .o_byte_out (w_byte),
    .o_last     (w_last)
  );

  // Sequencing FSM; every output is registered here so read and fifo_wren never overlap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_word_idx   <= '0;
      r_read       <= 1'b0;
      r_address    <= BASE_ADDR;
      r_fifo_wren  <= 1'b0;
      r_fifo_data  <= '0;
      r_fifo_sel   <= '0;
      r_fetch_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_word_idx <= '0;
          if (i_start) begin
            r_state   <= REQ;
            r_read    <= 1'b1;
            r_address <= BASE_ADDR;
            r_busy    <= 1'b1;
          end
        end
        REQ: begin
          if (!i_waitrequest) begin
            r_state <= WAIT;
            r_read  <= 1'b0;
          end
        end
        WAIT: begin
          if (i_readdatavalid) begin
            r_state     <= UNPACK;
            r_fifo_wren <= 1'b1;
            r_fifo_data <= w_byte;
            r_fifo_sel  <= 4'(r_word_idx);
          end
        end
        UNPACK: begin
          if (w_last) begin
            r_fifo_wren <= 1'b0;
            if (r_word_idx == IDX_W'(DIM)) begin
              r_state      <= DONE;
              r_fetch_done <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_state    <= REQ;
              r_word_idx <= r_word_idx + 1'b1;
              r_read     <= 1'b1;
              r_address  <= BASE_ADDR + ADDR_WIDTH'(r_word_idx) + ADDR_WIDTH'(1);
            end
          end else begin
            r_fifo_data <= w_byte;
          end
        end
        DONE: begin
          if (i_start) begin
            r_state      <= REQ;
            r_word_idx   <= '0;
            r_fetch_done <= 1'b0;
            r_read       <= 1'b1;
            r_address    <= BASE_ADDR;
            r_busy       <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_address    = r_address;
  assign o_read       = r_read;
  assign o_fifo_wren  = r_fifo_wren;
  assign o_fifo_data  = r_fifo_data;
  assign o_fifo_sel   = r_fifo_sel;
  assign o_fetch_done = r_fetch_done;

endmodule : avmm_data_fetcher
